debug_program_loader: RTL

//  Debug-unit side writer for the instruction-fetch program memory port. Packs 8-bit UART

---
 rtl/debug_program_loader_pkg.sv | 23 ++
 rtl/debug_program_loader_if.sv | 32 +++
 rtl/debug_byte_packer.sv | 46 ++++
 rtl/debug_program_loader.sv | 138 +++++++++++++
 4 files changed

// File: rtl/debug_program_loader_pkg.sv
// Purpose : shared widths, HALT marker and loader FSM state codes for the program loader and IF stage.
// Contents: widths of instruction word, program address and UART byte; state constants; word/addr/byte types.
// Users   : debug_program_loader_if, debug_byte_packer, debug_program_loader.
package debug_program_loader_pkg;

  localparam int RAM_WIDTH_PROGRAMA = 32;
  localparam int CANT_BITS_ADDR     = 11;
  localparam int RAM_DEPTH_PROGRAMA = 2048;
  localparam int CANT_BITS_BYTE     = 8;

  localparam logic [RAM_WIDTH_PROGRAMA-1:0] HALT_INSTRUCTION = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RECV  = 3'd1;
  localparam logic [2:0] ST_WRITE = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  typedef logic [RAM_WIDTH_PROGRAMA-1:0] word_t;
  typedef logic [CANT_BITS_ADDR-1:0]     addr_t;
  typedef logic [CANT_BITS_BYTE-1:0]     byte_t;

endpackage

// File: rtl/debug_program_loader_if.sv
// Purpose : bundles the UART-side inputs and program-memory-side outputs of the loader.
// Ports   : i_start_load, i_rx_data, i_rx_valid (host -> loader);
//           o_addr/o_data/o_write_read/o_enable/o_control_mux, o_busy, o_load_done, o_overflow (loader -> host).
// Modports: master = loader view, slave = host/memory view.
interface debug_program_loader_if;
  import debug_program_loader_pkg::*;

  logic  i_start_load;
  byte_t i_rx_data;
  logic  i_rx_valid;
  addr_t o_addr_mem_programa;
  word_t o_data_mem_programa;
  logic  o_write_read_mem;
  logic  o_enable_mem;
  logic  o_control_mux_addr_mem;
  logic  o_busy;
  logic  o_load_done;
  logic  o_overflow;

  modport master (
    input  i_start_load, i_rx_data, i_rx_valid,
    output o_addr_mem_programa, o_data_mem_programa, o_write_read_mem, o_enable_mem,
           o_control_mux_addr_mem, o_busy, o_load_done, o_overflow
  );

  modport slave (
    output i_start_load, i_rx_data, i_rx_valid,
    input  o_addr_mem_programa, o_data_mem_programa, o_write_read_mem, o_enable_mem,
           o_control_mux_addr_mem, o_busy, o_load_done, o_overflow
  );

endinterface

// File: rtl/debug_byte_packer.sv
// Purpose : shifts UART bytes into a 32-bit word, first byte ends up in the MSBs.
// Ports   : clk/rst, clr (restart byte count), in_vld/in_dat (accepted byte),
//           word_vld/word_dat (combinational: high on the 4th byte, word includes that byte).
module debug_byte_packer
  import debug_program_loader_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  clr,
  input  logic  in_vld,
  input  byte_t in_dat,
  output logic  word_vld,
  output word_t word_dat
);

  logic [1:0]  cnt_q, cnt_d;
  logic [23:0] shift_q, shift_d;

  // The completed word is formed from the three stored bytes plus the one on the bus,
  // so the loader can latch it on the same edge the 4th byte arrives.
  assign word_vld = in_vld && (cnt_q == 2'd3);
  assign word_dat = {shift_q, in_dat};

  always_comb begin
    cnt_d   = cnt_q;
    shift_d = shift_q;
    if (clr) begin
      cnt_d   = 2'd0;
      shift_d = 24'd0;
    end else if (in_vld) begin
      cnt_d   = cnt_q + 2'd1;
      shift_d = {shift_q[15:0], in_dat};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= 2'd0;
      shift_q <= 24'd0;
    end else begin
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: rtl/debug_program_loader.sv
// Purpose : loads a program from UART bytes into program memory from address 0 until HALT is written.
// Ports   : i_clock, i_soft_reset (async, active high), bus (master modport: UART in, memory write port out).
// Timing  : 4th byte at edge N -> write strobe during cycle N+1 -> next address from N+2.
module debug_program_loader
  import debug_program_loader_pkg::*;
#(
  parameter int    DEPTH     = RAM_DEPTH_PROGRAMA,
  parameter word_t HALT_WORD = HALT_INSTRUCTION
)
(
  input logic                    i_clock,
  input logic                    i_soft_reset,
  debug_program_loader_if.master bus
);

  logic [2:0] state_q, state_d;
  addr_t      addr_q, addr_d;
  word_t      data_q, data_d;
  logic       wr_q, wr_d;
  logic       en_q, en_d;
  logic       mux_q, mux_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       ovf_q, ovf_d;

  logic  accept;
  logic  clr;
  logic  word_vld;
  word_t word_dat;

  // Bytes are taken while receiving and also during the write cycle, so a byte
  // landing on the strobe becomes byte 0 of the next word.
  assign accept = bus.i_rx_valid && ((state_q == ST_RECV) || (state_q == ST_WRITE));
  assign clr    = bus.i_start_load && ((state_q == ST_IDLE) || (state_q == ST_ERROR));

  debug_byte_packer u_packer (
    .clk      (i_clock),
    .rst      (i_soft_reset),
    .clr      (clr),
    .in_vld   (accept),
    .in_dat   (bus.i_rx_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wr_d    = 1'b0;
    en_d    = en_q;
    mux_d   = mux_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_ERROR: begin
        if (bus.i_start_load) begin
          state_d = ST_RECV;
          addr_d  = '0;
          en_d    = 1'b1;
          mux_d   = 1'b1;
          busy_d  = 1'b1;
          ovf_d   = 1'b0;
        end
      end
      ST_RECV: begin
        if (word_vld) begin
          state_d = ST_WRITE;
          data_d  = word_dat;
          wr_d    = 1'b1;
        end
      end
      ST_WRITE: begin
        if (data_q == HALT_WORD) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          en_d    = 1'b0;
          mux_d   = 1'b0;
          busy_d  = 1'b0;
        end else if (addr_q == addr_t'(DEPTH - 1)) begin
          // Memory is full and no HALT seen: stop rather than wrap onto address 0.
          state_d = ST_ERROR;
          ovf_d   = 1'b1;
          en_d    = 1'b0;
          mux_d   = 1'b0;
          busy_d  = 1'b0;
        end else begin
          state_d = ST_RECV;
          addr_d  = addr_q + addr_t'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        en_d    = 1'b0;
        mux_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_soft_reset) begin
    if (i_soft_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      en_q    <= 1'b0;
      mux_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      en_q    <= en_d;
      mux_q   <= mux_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.o_addr_mem_programa    = addr_q;
  assign bus.o_data_mem_programa    = data_q;
  assign bus.o_write_read_mem       = wr_q;
  assign bus.o_enable_mem           = en_q;
  assign bus.o_control_mux_addr_mem = mux_q;
  assign bus.o_busy                 = busy_q;
  assign bus.o_load_done            = done_q;
  assign bus.o_overflow             = ovf_q;

endmodule
